// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction field positions and widths, opcodes, and fetch states.
// This package holds constants and types only, so latency and backpressure do not apply.
package isa_pkg;

    localparam int INSTR_W    = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 9;
    localparam int RS1_MSB    = 8;
    localparam int RS1_LSB    = 6;
    localparam int RS2_MSB    = 5;
    localparam int RS2_LSB    = 3;
    localparam int IMM_MSB    = 6;
    localparam int IMM_LSB    = 0;
    localparam int NZIMM_MSB  = 5;
    localparam int NZIMM_LSB  = 0;
    localparam int OFFSET_MSB = 8;
    localparam int OFFSET_LSB = 0;

    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int REG_W      = RD_MSB - RD_LSB + 1;
    localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;
    localparam int NZIMM_W    = NZIMM_MSB - NZIMM_LSB + 1;
    localparam int OFFSET_W   = OFFSET_MSB - OFFSET_LSB + 1;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LI   = 4'h5,
        OP_BEQ  = 4'h6,
        OP_BNE  = 4'h7,
        OP_JMP  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit drives the address, and the memory returns the word.
// The word is valid one cycle after the address; there is no backpressure.
interface instr_fetch_unit_if #(
    parameter int PC_W = 8
);
    import isa_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/pc_next_logic.sv
// PC commit value: 0 on the first step, pc+sext(offset) on a taken branch (IFU_BRANCH_EN only), else pc+1.
// This block is purely combinational, so it has no latency and no backpressure.
module pc_next_logic
    import isa_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]     pc,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                take_branch,
    input  logic                first_step,
    output logic [PC_W-1:0]     next_pc
);

    logic [PC_W-1:0] offset_ext;
    logic            branch;

    // Sign-extend the offset, or truncate it, so that the sum wraps modulo 2^PC_W.
    generate
        if (PC_W > OFFSET_W) begin : g_sext
            assign offset_ext = {{(PC_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
        end else begin : g_trunc
            logic unused_offset;
            assign unused_offset = ^offset;
            assign offset_ext    = offset[PC_W-1:0];
        end
    endgenerate

`ifdef IFU_BRANCH_EN
    assign branch = take_branch;
`else
    logic unused_take_branch;
    assign unused_take_branch = take_branch;
    assign branch             = 1'b0;
`endif

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (first_step) begin
            next_pc = '0;
        end else if (branch) begin
            next_pc = pc + offset_ext;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Step-driven fetch and issue of one instruction. instr_valid follows the step edge by 2 cycles; IFU_BRANCH_EN enables branches.
// A step during FETCH, ISSUE or HALT is dropped and is not queued, and only reset leaves HALT.
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter int                  PC_W        = 8,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = OP_HALT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic                 take_branch,
    instr_fetch_unit_if.master   imem,
    output logic [PC_W-1:0]      pc,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_W-1:0]     rd,
    output logic [REG_W-1:0]     rs1,
    output logic [REG_W-1:0]     rs2,
    output logic [IMM_W-1:0]     immediate,
    output logic [NZIMM_W-1:0]   nzimm,
    output logic [OFFSET_W-1:0]  offset,
    output logic                 instr_valid,
    output logic                 halted
);

    fetch_state_e       state, state_nxt;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    addr_q;
    logic [PC_W-1:0]    pc_commit;
    logic [INSTR_W-1:0] instr_q;
    logic               started_q;
    logic               step_accept;

    assign step_accept = (state == ST_IDLE) && step;

    pc_next_logic #(
        .PC_W        (PC_W)
    ) u_pc_next (
        .pc          (pc_q),
        .offset      (instr_q[OFFSET_MSB:OFFSET_LSB]),
        .take_branch (take_branch),
        .first_step  (!started_q),
        .next_pc     (pc_commit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (step) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = (instr_q[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) ? ST_HALT : ST_IDLE;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // pc and the fetched word change only on an accepted step and at the end of FETCH, so they stay stable during ISSUE and IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            addr_q    <= '0;
            instr_q   <= '0;
            started_q <= 1'b0;
        end else begin
            if (step_accept) begin
                pc_q      <= pc_commit;
                addr_q    <= pc_commit;
                started_q <= 1'b1;
            end
            if (state == ST_FETCH) begin
                instr_q <= imem.imem_data;
            end
        end
    end

    assign imem.imem_addr = addr_q;
    assign pc             = pc_q;

    assign opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign rd        = instr_q[RD_MSB:RD_LSB];
    assign rs1       = instr_q[RS1_MSB:RS1_LSB];
    assign rs2       = instr_q[RS2_MSB:RS2_LSB];
    assign immediate = instr_q[IMM_MSB:IMM_LSB];
    assign nzimm     = instr_q[NZIMM_MSB:NZIMM_LSB];
    assign offset    = instr_q[OFFSET_MSB:OFFSET_LSB];

    assign instr_valid = (state == ST_ISSUE);
    assign halted      = (state == ST_HALT);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-memory address width.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'hF, meaning the opcode that stops sequencing.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port step, input, 1, single-cycle pulse (debounced pushbutton) requesting the next instruction.
REQ-006 SHALL have port take_branch, input, 1, the ALU branch decision for the currently issued instruction.
REQ-007 SHALL have port imem_addr, output, PC_W, the instruction-memory read address.
REQ-008 SHALL have port imem_data, input, 16, the instruction word, valid one cycle after imem_addr.
REQ-009 SHALL have port pc, output, PC_W, the address of the currently issued instruction.
REQ-010 SHALL have ports opcode (4), rd (3), rs1 (3), rs2 (3), immediate (7), nzimm (6) and offset (9), all outputs, the decoded fields presented to instruction_decoder and the register file.
REQ-011 SHALL have port instr_valid, output, 1, one-cycle pulse when new fields are presented.
REQ-012 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-013 SHALL implement the states IDLE, FETCH, ISSUE and HALT.
REQ-014 IDLE + step SHALL commit the PC (REQ-017), drive imem_addr with the new PC, and enter FETCH.
REQ-015 FETCH SHALL register imem_data into the field outputs on the next edge and enter ISSUE.
REQ-016 ISSUE SHALL pulse instr_valid for exactly one cycle and enter HALT if opcode == HALT_OPCODE, otherwise enter IDLE.
REQ-017 PC commit: the first step after reset SHALL keep pc = 0; each later step SHALL set pc = pc + sign_extend(offset) when take_branch = 1, otherwise pc + 1.
REQ-018 PC arithmetic SHALL be modulo 2^PC_W: offset is truncated to PC_W bits, and 8'hFF + 1 wraps to 8'h00.
REQ-019 Field extraction SHALL be opcode = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], immediate = [6:0], nzimm = [5:0], offset = [8:0].
REQ-020 Field outputs and pc SHALL hold stable from ISSUE until the next FETCH completes.
REQ-021 A step asserted during FETCH, ISSUE or HALT SHALL be ignored and SHALL NOT be queued.
REQ-022 take_branch SHALL be sampled only on the IDLE + step edge.
REQ-023 Fetch latency SHALL be 2 cycles from the step edge to instr_valid.
REQ-024 HALT SHALL be left only by reset.

Reset
REQ-025 reset SHALL force the state to IDLE, and pc, imem_addr, all field outputs, instr_valid and halted to 0, immediately and independent of clk.
REQ-026 A reset mid-FETCH SHALL discard the pending word, and the next step SHALL fetch address 0.

Configuration
REQ-027 With IFU_BRANCH_EN defined, the block SHALL behave as in REQ-017.
REQ-028 Without IFU_BRANCH_EN, the block SHALL ignore take_branch and always advance by pc + 1.

Structure
REQ-029 The shared package isa_pkg SHALL hold the field bit positions, field widths, the opcode enum including HALT, and the fetch-state enum.
REQ-030 The PC-commit adder and mux SHALL be one sub-module, pc_next_logic; field slicing SHALL stay inline.

Verification
REQ-031 Reset, imem[0] = 16'h1A47, one step -> pc = 0, imem_addr = 0, opcode = 1, rd = 5, rs1 = 1, rs2 = 0, instr_valid high exactly 2 cycles after step.
REQ-032 Sequential run, three steps with take_branch = 0 -> pc = 0, 1, 2; exactly three instr_valid pulses.
REQ-033 Branch: pc = 4, offset = 9'h1FE (-2), take_branch = 1, step -> pc = 2; with IFU_BRANCH_EN undefined -> pc = 5.
REQ-034 Wrap: pc = 8'hFF, take_branch = 0, step -> pc = 8'h00 and imem_addr = 0.
REQ-035 Halt: imem[3] = 16'hF000 issued -> halted = 1; further steps -> no instr_valid and pc unchanged; reset -> halted = 0, pc = 0.
REQ-036 Step ignored and reset mid-fetch: step re-pulsed during FETCH -> one instr_valid only; reset asserted during FETCH -> all outputs 0 asynchronously, and the next step fetches address 0.
